// File: rtl/gate_exhaustive_tester.sv
// gate_exhaustive_tester: exhaustive stimulus/checker for a single N_IN-input cell
// Ports: clk, rst (async active-high), start_i (begin run in IDLE/DONE),
//        dut_in_o (drive to cell), dut_out_i (cell output, async to clk),
//        busy_o, done_o, pass_o, fail_vec_o (first failing vector), fail_count_o.
module gate_exhaustive_tester #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter     TRUTH         = 4'b0111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    output logic [N_IN-1:0] dut_in_o,
    input  logic            dut_out_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN-1:0] fail_vec_o,
    output logic [N_IN:0]   fail_count_o
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = N_IN + 1;

    if (SETTLE_CYCLES < 2 || $bits(TRUTH) != 2**N_IN) begin : g_bad
        $error("gate_exhaustive_tester: SETTLE_CYCLES < 2 or TRUTH width != 2**N_IN");
    end

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [N_IN-1:0] vec_d;
    logic [N_IN-1:0] fail_vec_q;
    logic [CW-1:0]   fail_cnt_q;
    logic [SW-1:0]   settle_q;
    logic            first_q;
    logic            busy_q;
    logic            done_q;
    logic            y1_q;
    logic            y2_q;
    logic            mismatch;
    logic            last_vec;

    // y2_q is the synchronised cell output; nothing else looks at dut_out_i
    always_comb begin
        vec_d    = vec_q + N_IN'(1);
        mismatch = y2_q != TRUTH[vec_q];
        last_vec = vec_q == {N_IN{1'b1}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            fail_vec_q <= '0;
            fail_cnt_q <= '0;
            settle_q   <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y1_q       <= 1'b0;
            y2_q       <= 1'b0;
        end else begin
            y1_q <= dut_out_i;
            y2_q <= y1_q;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= SETTLE;
                        vec_q      <= '0;
                        settle_q   <= SW'(SETTLE_CYCLES);
                        fail_cnt_q <= '0;
                        fail_vec_q <= '0;
                        first_q    <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SETTLE: begin
                    settle_q <= settle_q - SW'(1);
                    if (settle_q == SW'(1))
                        state_q <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        fail_cnt_q <= fail_cnt_q + CW'(1);
                        if (!first_q) begin
                            fail_vec_q <= vec_q;
                            first_q    <= 1'b1;
                        end
                    end
                    if (last_vec) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        vec_q    <= vec_d;
                        settle_q <= SW'(SETTLE_CYCLES);
                        state_q  <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dut_in_o     = vec_q;
        busy_o       = busy_q;
        done_o       = done_q;
        fail_vec_o   = fail_vec_q;
        fail_count_o = fail_cnt_q;
        pass_o       = done_q && fail_cnt_q == '0;
    end
endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// tb_gate_exhaustive_tester: directed table-driven bench for gate_exhaustive_tester
module tb_gate_exhaustive_tester;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass;
    logic [1:0] fail_vec;
    logic [2:0] fail_count;
    int         mode = 0;
    int         passed = 0;
    int         total = 0;

    typedef struct {
        int         mode;
        logic [2:0] cnt;
        logic [1:0] fvec;
        logic       ps;
        logic       pulse;
    } run_t;

    run_t runs[6];

    always #5 clk = ~clk;

    // behavioural cell: 0 = NAND, 1 = stuck-at-1, 2 = stuck-at-0
    assign dut_out = (mode == 0) ? ~&dut_in : (mode == 1);

    gate_exhaustive_tester dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .dut_in_o     (dut_in),
        .dut_out_i    (dut_out),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .fail_vec_o   (fail_vec),
        .fail_count_o (fail_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_idle_zero(input string name);
        chk(name, {26'd0, dut_in, busy, done, pass, fail_vec, fail_count}, 32'd0);
    endtask

    // one start-to-done run; checks every cycle's dut_in/busy/done/pass and the final results
    task automatic do_run(input run_t r);
        logic [1:0] ev;
        mode  = r.mode;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("cleared_on_accept", {27'd0, fail_count, fail_vec}, 32'd0);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (r.pulse && (k == 3 || k == 9)) start = 1'b0;
            ev = (k < 16) ? 2'(k / 4) : 2'd3;
            chk($sformatf("trace_k%0d", k), {27'd0, done, busy, pass, ev == dut_in},
                {27'd0, k == 16, k < 16, (k == 16) && r.ps, 1'b1});
            if (r.pulse && (k == 2 || k == 8)) start = 1'b1;
        end
        chk("fail_count", 32'(fail_count), 32'(r.cnt));
        chk("fail_vec", 32'(fail_vec), 32'(r.fvec));
        chk("pass", 32'(pass), 32'(r.ps));
    endtask

    initial begin
        runs[0] = '{mode: 0, cnt: 3'd0, fvec: 2'd0, ps: 1'b1, pulse: 1'b0};
        runs[1] = '{mode: 1, cnt: 3'd1, fvec: 2'd3, ps: 1'b0, pulse: 1'b0};
        runs[2] = '{mode: 2, cnt: 3'd3, fvec: 2'd0, ps: 1'b0, pulse: 1'b0};
        runs[3] = '{mode: 0, cnt: 3'd0, fvec: 2'd0, ps: 1'b1, pulse: 1'b1};
        runs[4] = '{mode: 1, cnt: 3'd1, fvec: 2'd3, ps: 1'b0, pulse: 1'b0};
        runs[5] = '{mode: 0, cnt: 3'd0, fvec: 2'd0, ps: 1'b1, pulse: 1'b0};
        repeat (3) @(posedge clk);
        #1 chk_idle_zero("reset_outputs");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_zero("idle_after_release");
        for (int i = 0; i < 6; i++) begin
            do_run(runs[i]);
            repeat (2) @(posedge clk);
            #1 chk($sformatf("done_held_run%0d", i), {30'd0, done, busy}, 32'b10);
        end
        // stuck-at-0 run aborted by reset at cycle 7, then a clean NAND run
        mode  = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_idle_zero("async_reset_midrun");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk_idle_zero("idle_after_midrun_reset");
        do_run(runs[0]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
